imem_loader: RTL and testbench

Byte-serial program loader that writes 32-bit MIPS instructions into the instruction memory the fetch stage reads. It sits in front of the instruction RAM's write port and holds the five-stage pipeline in reset (`cpu_hold`) until a complete, checksum-verified program image has been written. It is the write side of the instruction-memory interface; the fetch stage remains the only reader.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_packer.sv | 60 ++++++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-serial instruction-memory loader.
package imem_loader_pkg;

  // Bytes per MIPS instruction word.
  localparam int WORD_BYTES = 4;

  // Width of the big-endian word-count field at the head of an image.
  localparam int LEN_W = 16;

  // Loader progress through one image.
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted instruction bytes, MSB first, into 32-bit words.
// It also keeps the running XOR of every byte it sees. word_valid pulses
// for the one cycle after the fourth byte of a word, and during that
// cycle word holds the completed word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,         // synchronous, active-low
  input  logic        clr,         // restart: drop partial word and checksum
  input  logic        byte_valid,  // an instruction byte is accepted this cycle
  input  logic [7:0]  byte_data,
  output logic        last_byte,   // the next accepted byte completes a word
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;
  logic [7:0]  xor_q;
  logic        word_valid_q;

  // Shift bytes in, fold them into the checksum, and emit each completed word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= 2'd0;
      shift_q      <= 24'd0;
      word_q       <= 32'd0;
      xor_q        <= 8'd0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clr) begin
        cnt_q   <= 2'd0;
        shift_q <= 24'd0;
        word_q  <= 32'd0;
        xor_q   <= 8'd0;
      end else if (byte_valid) begin
        xor_q   <= xor_q ^ byte_data;
        // The 2-bit counter wraps to zero after the fourth byte.
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[15:0], byte_data};
        if (cnt_q == LAST_IDX) begin
          word_q       <= {shift_q, byte_data};
          word_valid_q <= 1'b1;
        end
      end
    end
  end

  assign last_byte  = (cnt_q == LAST_IDX);
  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign csum       = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader for the instruction memory.
// It writes a length-prefixed, XOR-checksummed image into the instruction
// RAM and holds the pipeline in reset until a good image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8  // word-address width; must be below LEN_W
) (
  input  logic              clk,
  input  logic              rst,        // synchronous, active-low
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Largest image that fits the memory: one word per address.
  localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

  state_t              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cpu_hold_q;
  logic                done_q;
  logic                error_q;

  logic                accept;
  logic                restart;
  logic [LEN_W-1:0]    len_full;
  logic                pk_valid;
  logic                pk_last_byte;
  logic                pk_word_valid;
  logic [31:0]         pk_word;
  logic [7:0]          pk_csum;

  // Bytes are only taken while an image is in progress.
  assign in_ready = (state_q != DONE) && (state_q != ERR);
  assign accept   = in_valid && in_ready;
  // start only counts once the previous load has finished, good or bad.
  assign restart  = start && !in_ready;
  assign len_full = {len_q[LEN_W-1:8], in_data};
  assign pk_valid = accept && (state_q == DATA);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .last_byte  (pk_last_byte),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .csum       (pk_csum)
  );

  // Loader FSM: length header, payload words, checksum, then hold the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LEN_HI;
      len_q      <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // Advance past each written word; wraps only after the final word of a full image.
      if (pk_word_valid) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      case (state_q)
        LEN_HI: begin
          if (accept) begin
            len_q   <= {in_data, len_q[7:0]};
            state_q <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_q <= len_full;
            if (32'(len_full) > MAX_LEN) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else if (len_full == '0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && pk_last_byte) begin
            wcnt_q <= wcnt_q + LEN_W'(1);
            if (wcnt_q == len_q - LEN_W'(1)) begin
              state_q <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (in_data == pk_csum) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            state_q    <= LEN_HI;
            len_q      <= '0;
            wcnt_q     <= '0;
            addr_q     <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= LEN_HI;
        end
      endcase
    end
  end

  assign mem_we    = pk_word_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = pk_word;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes go into a scoreboard
// queue as bytes are driven; observed writes are compared in order.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  logic [31:0] img[256];

  imem_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // One clock; records any write strobe seen just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives a whole image from img[]; checksum computed here from the words.
  task automatic send_image(input int n, input bit good, input logic [7:0] bad_csum, input bit gap);
    logic [7:0]  x;
    logic [15:0] len;
    logic [31:0] w;
    logic [7:0]  b;
    x   = 8'h00;
    len = 16'(n);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        x = x ^ b;
        if (k == 0) exp_q.push_back({8'(i), w});
        send_byte(b);
        if (gap) step();
      end
    end
    send_byte(good ? x : bad_csum);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", error); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b1;
    step();
    $display("test_reset: outputs checked");
  endtask

  task automatic test_basic();
    logic [39:0] e, o;
    int ne;
    img[0] = 32'h20080005;
    img[1] = 32'h8C090004;
    send_image(2, 1'b1, 8'h00, 1'b0);
    ne = exp_q.size();
    vectors++; if (obs_q.size() != ne) begin miscompares++; $display("FAIL basic_nwrites: got %0d expected %0d", obs_q.size(), ne); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL basic_write: got %h expected %h", o, e); end
    end
    obs_q.delete();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done: got %b expected 1", done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL basic_cpu_hold: got %b expected 0", cpu_hold); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b expected 0", error); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready: got %b expected 0", in_ready); end
    $display("test_basic: N=2 image, done=%b cpu_hold=%b", done, cpu_hold);
  endtask

  task automatic test_bad_csum();
    logic [39:0] e, o;
    int ne;
    pulse_start();
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL restart_cpu_hold: got %b expected 1", cpu_hold); end
    img[0] = 32'h20080005;
    img[1] = 32'h8C090004;
    send_image(2, 1'b0, 8'h3D, 1'b0);
    ne = exp_q.size();
    vectors++; if (obs_q.size() != ne) begin miscompares++; $display("FAIL badcs_nwrites: got %0d expected %0d", obs_q.size(), ne); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL badcs_write: got %h expected %h", o, e); end
    end
    obs_q.delete();
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL badcs_error: got %b expected 1", error); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL badcs_cpu_hold: got %b expected 1", cpu_hold); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL badcs_in_ready: got %b expected 0", in_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL badcs_done: got %b expected 0", done); end
    $display("test_bad_csum: error=%b cpu_hold=%b", error, cpu_hold);
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_image(0, 1'b1, 8'h00, 1'b0);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL zero_nwrites: got %0d expected 0", obs_q.size()); end
    obs_q.delete();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL zero_cpu_hold: got %b expected 0", cpu_hold); end
    $display("test_zero_len: done=%b", done);
  endtask

  task automatic test_overflow();
    pulse_start();
    send_byte(8'h01);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL ovf_early_error: got %b expected 0", error); end
    send_byte(8'h01);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL ovf_error: got %b expected 1", error); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_in_ready: got %b expected 0", in_ready); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL ovf_cpu_hold: got %b expected 1", cpu_hold); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL ovf_nwrites: got %0d expected 0", obs_q.size()); end
    obs_q.delete();
    $display("test_overflow: N=257 error=%b", error);
  endtask

  task automatic test_full();
    logic [39:0] e, o;
    int ne;
    pulse_start();
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    send_image(256, 1'b1, 8'h00, 1'b1);
    ne = exp_q.size();
    vectors++; if (obs_q.size() != ne) begin miscompares++; $display("FAIL full_nwrites: got %0d expected %0d", obs_q.size(), ne); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL full_write: got %h expected %h", o, e); end
    end
    obs_q.delete();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL full_done: got %b expected 1", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL full_error: got %b expected 0", error); end
    $display("test_full: N=256 done=%b", done);
  endtask

  task automatic test_reset_midload();
    logic [39:0] e, o;
    int ne;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({8'h00, 32'h20080005});
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL midrst_addr: got %h expected 00", mem_addr); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL midrst_cpu_hold: got %b expected 1", cpu_hold); end
    img[0] = 32'h11223344;
    img[1] = 32'h55667788;
    send_image(2, 1'b1, 8'h00, 1'b0);
    ne = exp_q.size();
    vectors++; if (obs_q.size() != ne) begin miscompares++; $display("FAIL midrst_nwrites: got %0d expected %0d", obs_q.size(), ne); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL midrst_write: got %h expected %h", o, e); end
    end
    obs_q.delete();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL midrst_done: got %b expected 1", done); end
    $display("test_reset_midload: reload done=%b", done);
  endtask

  task automatic test_start_in_done();
    logic [39:0] e, o;
    int ne;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL sid_done: got %b expected 0", done); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL sid_cpu_hold: got %b expected 1", cpu_hold); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sid_in_ready: got %b expected 1", in_ready); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL sid_error: got %b expected 0", error); end
    img[0] = 32'hDEADBEEF;
    send_image(1, 1'b1, 8'h00, 1'b0);
    ne = exp_q.size();
    vectors++; if (obs_q.size() != ne) begin miscompares++; $display("FAIL sid_nwrites: got %0d expected %0d", obs_q.size(), ne); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL sid_write: got %h expected %h", o, e); end
    end
    obs_q.delete();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sid_reload_done: got %b expected 1", done); end
    $display("test_start_in_done: 0xFF ignored, reload done=%b", done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_zero_len();
    test_overflow();
    test_full();
    test_reset_midload();
    test_start_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
